// File: rtl/sram_bus_initiator_if.sv
// Request/response and SRAM-controller bus bundle for sram_bus_initiator.
// master is the initiator's view; slave is the CPU-stage/controller side.
interface sram_bus_initiator_if #(
    parameter int ADDR_W = 20
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [31:0]       req_addr;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic              read_op;
    logic              write_op;
    logic [ADDR_W-1:0] bus_addr;
    logic [3:0]        byte_mask;
    logic [31:0]       bus_data_write;
    logic [31:0]       bus_data_read;
    logic              bus_stall;

    modport master (
        input  req_valid, req_write, req_addr, req_size, req_signed, req_wdata,
        input  bus_data_read, bus_stall,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output read_op, write_op, bus_addr, byte_mask, bus_data_write
    );

    modport slave (
        output req_valid, req_write, req_addr, req_size, req_signed, req_wdata,
        output bus_data_read, bus_stall,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  read_op, write_op, bus_addr, byte_mask, bus_data_write
    );
endinterface

// File: rtl/sram_bus_initiator.sv
// Single-request load/store initiator for the SRAM controller bus: size/alignment
// decode, lane replication, fixed-length access window and load data extension.
module sram_bus_initiator #(
    parameter int ACCESS_CYCLES = 3,
    parameter int ADDR_W        = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    sram_bus_initiator_if.master  bus
);

    localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_GAP    = 2'b10
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [1:0]        r_addr_lo;
    logic [1:0]        w_addr_lo_nxt;
    logic [1:0]        r_size;
    logic [1:0]        w_size_nxt;
    logic              r_signed;
    logic              w_signed_nxt;
    logic              r_read_op;
    logic              w_read_op_nxt;
    logic              r_write_op;
    logic              w_write_op_nxt;
    logic [ADDR_W-1:0] r_bus_addr;
    logic [ADDR_W-1:0] w_bus_addr_nxt;
    logic [3:0]        r_byte_mask;
    logic [3:0]        w_byte_mask_nxt;
    logic [31:0]       r_bus_data_write;
    logic [31:0]       w_bus_data_write_nxt;
    logic              r_resp_valid;
    logic              w_resp_valid_nxt;
    logic              r_resp_err;
    logic              w_resp_err_nxt;
    logic [31:0]       r_resp_rdata;
    logic [31:0]       w_resp_rdata_nxt;

    logic              w_accept;
    logic              w_aligned;
    logic              w_cnt_zero;

    function automatic logic f_aligned(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SZ_BYTE: f_aligned = 1'b1;
            SZ_HALF: f_aligned = (lo[0] == 1'b0);
            SZ_WORD: f_aligned = (lo == 2'b00);
            default: f_aligned = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] f_byte_mask(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SZ_BYTE: f_byte_mask = 4'b0001 << lo;
            SZ_HALF: f_byte_mask = lo[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: f_byte_mask = 4'b1111;
            default: f_byte_mask = 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] f_lanes(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            SZ_BYTE: f_lanes = {4{wdata[7:0]}};
            SZ_HALF: f_lanes = {2{wdata[15:0]}};
            SZ_WORD: f_lanes = wdata;
            default: f_lanes = 32'h0000_0000;
        endcase
    endfunction

    // Loads: bring the addressed bytes down to bit 0, then sign- or zero-extend.
    function automatic logic [31:0] f_extract(input logic [31:0] rdata, input logic [1:0] lo,
                                              input logic [1:0] size, input logic sgn);
        logic [31:0] shifted;
        shifted = rdata >> {lo, 3'b000};
        case (size)
            SZ_BYTE: f_extract = {{24{sgn & shifted[7]}}, shifted[7:0]};
            SZ_HALF: f_extract = {{16{sgn & shifted[15]}}, shifted[15:0]};
            SZ_WORD: f_extract = rdata;
            default: f_extract = 32'h0000_0000;
        endcase
    endfunction

    assign w_accept   = bus.req_valid && (r_state == ST_IDLE);
    assign w_aligned  = f_aligned(bus.req_size, bus.req_addr[1:0]);
    assign w_cnt_zero = (r_cnt == CNT_ZERO);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_aligned ? ST_ACCESS : ST_GAP;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (!bus.bus_stall && w_cnt_zero) begin
                    w_state_nxt = ST_GAP;
                end else begin
                    w_state_nxt = ST_ACCESS;
                end
            end
            ST_GAP:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs and request context.
    always_comb begin
        w_cnt_nxt            = r_cnt;
        w_addr_lo_nxt        = r_addr_lo;
        w_size_nxt           = r_size;
        w_signed_nxt         = r_signed;
        w_read_op_nxt        = r_read_op;
        w_write_op_nxt       = r_write_op;
        w_bus_addr_nxt       = r_bus_addr;
        w_byte_mask_nxt      = r_byte_mask;
        w_bus_data_write_nxt = r_bus_data_write;
        w_resp_valid_nxt     = 1'b0;
        w_resp_err_nxt       = 1'b0;
        w_resp_rdata_nxt     = r_resp_rdata;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && w_aligned) begin
                    w_addr_lo_nxt        = bus.req_addr[1:0];
                    w_size_nxt           = bus.req_size;
                    w_signed_nxt         = bus.req_signed;
                    w_bus_addr_nxt       = bus.req_addr[ADDR_W+1:2];
                    w_byte_mask_nxt      = f_byte_mask(bus.req_size, bus.req_addr[1:0]);
                    w_bus_data_write_nxt = f_lanes(bus.req_size, bus.req_wdata);
                    w_read_op_nxt        = ~bus.req_write;
                    w_write_op_nxt       = bus.req_write;
                    w_cnt_nxt            = CNT_LOAD;
                end else if (w_accept) begin
                    w_resp_valid_nxt = 1'b1;
                    w_resp_err_nxt   = 1'b1;
                    w_resp_rdata_nxt = 32'h0000_0000;
                end else begin
                    w_read_op_nxt  = 1'b0;
                    w_write_op_nxt = 1'b0;
                end
            end
            ST_ACCESS: begin
                if (bus.bus_stall) begin
                    w_cnt_nxt = r_cnt;
                end else if (!w_cnt_zero) begin
                    w_cnt_nxt = r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    w_read_op_nxt    = 1'b0;
                    w_write_op_nxt   = 1'b0;
                    w_resp_valid_nxt = 1'b1;
                    w_resp_err_nxt   = 1'b0;
                    w_resp_rdata_nxt = r_read_op ?
                        f_extract(bus.bus_data_read, r_addr_lo, r_size, r_signed) : 32'h0000_0000;
                end
            end
            ST_GAP: begin
                w_read_op_nxt  = 1'b0;
                w_write_op_nxt = 1'b0;
            end
            default: begin
                w_read_op_nxt  = 1'b0;
                w_write_op_nxt = 1'b0;
            end
        endcase
    end

    // Output and context registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt            <= CNT_ZERO;
            r_addr_lo        <= 2'b00;
            r_size           <= 2'b00;
            r_signed         <= 1'b0;
            r_read_op        <= 1'b0;
            r_write_op       <= 1'b0;
            r_bus_addr       <= {ADDR_W{1'b0}};
            r_byte_mask      <= 4'b0000;
            r_bus_data_write <= 32'h0000_0000;
            r_resp_valid     <= 1'b0;
            r_resp_err       <= 1'b0;
            r_resp_rdata     <= 32'h0000_0000;
        end else begin
            r_cnt            <= w_cnt_nxt;
            r_addr_lo        <= w_addr_lo_nxt;
            r_size           <= w_size_nxt;
            r_signed         <= w_signed_nxt;
            r_read_op        <= w_read_op_nxt;
            r_write_op       <= w_write_op_nxt;
            r_bus_addr       <= w_bus_addr_nxt;
            r_byte_mask      <= w_byte_mask_nxt;
            r_bus_data_write <= w_bus_data_write_nxt;
            r_resp_valid     <= w_resp_valid_nxt;
            r_resp_err       <= w_resp_err_nxt;
            r_resp_rdata     <= w_resp_rdata_nxt;
        end
    end

    assign bus.req_ready      = (r_state == ST_IDLE);
    assign bus.read_op        = r_read_op;
    assign bus.write_op       = r_write_op;
    assign bus.bus_addr       = r_bus_addr;
    assign bus.byte_mask      = r_byte_mask;
    assign bus.bus_data_write = r_bus_data_write;
    assign bus.resp_valid     = r_resp_valid;
    assign bus.resp_err       = r_resp_err;
    assign bus.resp_rdata     = r_resp_rdata;

endmodule

// File: tb/tb_sram_bus_initiator.sv
// Directed bench for sram_bus_initiator: loads, stores, misalignment, stall and reset.
module tb_sram_bus_initiator;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    int          g_rd_cyc;
    int          g_wr_cyc;
    int          g_both;
    int          g_lat;
    logic [31:0] g_rdata;
    logic        g_err;
    logic [19:0] g_addr;
    logic [3:0]  g_mask;
    logic [31:0] g_wdata;

    sram_bus_initiator_if #(.ADDR_W(20)) bus_if ();

    sram_bus_initiator #(.ACCESS_CYCLES(3), .ADDR_W(20)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One request; stall is driven high for edges stall_at..stall_at+stall_len-1 after acceptance.
    task automatic run_req(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                           input logic sgn, input logic [31:0] wdata,
                           input int stall_at, input int stall_len);
        @(negedge clk);
        chk("req_ready_idle", {31'd0, bus_if.req_ready}, 32'd1);
        bus_if.req_valid  = 1'b1;
        bus_if.req_write  = wr;
        bus_if.req_addr   = addr;
        bus_if.req_size   = size;
        bus_if.req_signed = sgn;
        bus_if.req_wdata  = wdata;
        bus_if.bus_stall  = (stall_at == 1) && (stall_len > 0);
        @(posedge clk);
        #1;
        bus_if.req_valid = 1'b0;
        bus_if.req_wdata = 32'h5555_5555;
        g_rd_cyc = 0; g_wr_cyc = 0; g_both = 0; g_lat = 0;
        g_rdata = 32'hxxxx_xxxx; g_err = 1'bx;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) begin
                g_addr  = bus_if.bus_addr;
                g_mask  = bus_if.byte_mask;
                g_wdata = bus_if.bus_data_write;
            end
            if (bus_if.read_op)  g_rd_cyc++;
            if (bus_if.write_op) g_wr_cyc++;
            if (bus_if.read_op && bus_if.write_op) g_both++;
            bus_if.bus_stall = (k + 1 >= stall_at) && (k + 1 < stall_at + stall_len);
            if (bus_if.resp_valid) begin
                g_lat   = k;
                g_rdata = bus_if.resp_rdata;
                g_err   = bus_if.resp_err;
                break;
            end
        end
        bus_if.bus_stall = 1'b0;
        @(negedge clk);
        chk("resp_pulse_len", {31'd0, bus_if.resp_valid}, 32'd0);
        chk("ops_never_both", g_both, 32'd0);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        bus_if.req_valid = 1'b0;  bus_if.req_write = 1'b0;  bus_if.req_addr = 32'd0;
        bus_if.req_size = 2'b00;  bus_if.req_signed = 1'b0; bus_if.req_wdata = 32'd0;
        bus_if.bus_data_read = 32'd0; bus_if.bus_stall = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_read_op",   {31'd0, bus_if.read_op},    32'd0);
        chk("rst_write_op",  {31'd0, bus_if.write_op},   32'd0);
        chk("rst_resp_valid",{31'd0, bus_if.resp_valid}, 32'd0);
        chk("rst_bus_addr",  {12'd0, bus_if.bus_addr},   32'd0);
        chk("rst_mask",      {28'd0, bus_if.byte_mask},  32'd0);
        chk("rst_rdata",     bus_if.resp_rdata,          32'd0);
        rst = 1'b0;

        // Word read
        bus_if.bus_data_read = 32'hDEAD_BEEF;
        run_req(1'b0, 32'h0000_0010, 2'b10, 1'b0, 32'd0, 0, 0);
        chk("lw_addr", {12'd0, g_addr}, 32'h4);
        chk("lw_mask", {28'd0, g_mask}, 32'hF);
        chk("lw_rd_cyc", g_rd_cyc, 32'd3);
        chk("lw_wr_cyc", g_wr_cyc, 32'd0);
        chk("lw_lat", g_lat, 32'd4);
        chk("lw_rdata", g_rdata, 32'hDEAD_BEEF);
        chk("lw_err", {31'd0, g_err}, 32'd0);

        // Signed and unsigned byte read of the top lane
        bus_if.bus_data_read = 32'h8011_2233;
        run_req(1'b0, 32'h0000_0013, 2'b00, 1'b1, 32'd0, 0, 0);
        chk("lb_mask", {28'd0, g_mask}, 32'h8);
        chk("lb_addr", {12'd0, g_addr}, 32'h4);
        chk("lb_rdata", g_rdata, 32'hFFFF_FF80);
        run_req(1'b0, 32'h0000_0013, 2'b00, 1'b0, 32'd0, 0, 0);
        chk("lbu_rdata", g_rdata, 32'h0000_0080);

        // Signed half read, upper half
        bus_if.bus_data_read = 32'h8001_7FFF;
        run_req(1'b0, 32'h0000_0002, 2'b01, 1'b1, 32'd0, 0, 0);
        chk("lh_mask", {28'd0, g_mask}, 32'hC);
        chk("lh_rdata", g_rdata, 32'hFFFF_8001);

        // Half store
        run_req(1'b1, 32'h0000_0022, 2'b01, 1'b0, 32'h0000_ABCD, 0, 0);
        chk("sh_addr", {12'd0, g_addr}, 32'h8);
        chk("sh_mask", {28'd0, g_mask}, 32'hC);
        chk("sh_wdata", g_wdata, 32'hABCD_ABCD);
        chk("sh_wr_cyc", g_wr_cyc, 32'd3);
        chk("sh_rd_cyc", g_rd_cyc, 32'd0);
        chk("sh_rdata", g_rdata, 32'd0);
        chk("sh_lat", g_lat, 32'd4);

        // Byte store
        run_req(1'b1, 32'h0000_0005, 2'b00, 1'b0, 32'h1234_56A5, 0, 0);
        chk("sb_addr", {12'd0, g_addr}, 32'h1);
        chk("sb_mask", {28'd0, g_mask}, 32'h2);
        chk("sb_wdata", g_wdata, 32'hA5A5_A5A5);

        // Misaligned word, misaligned half, illegal size
        run_req(1'b0, 32'h0000_0021, 2'b10, 1'b0, 32'd0, 0, 0);
        chk("mis_w_err", {31'd0, g_err}, 32'd1);
        chk("mis_w_lat", g_lat, 32'd1);
        chk("mis_w_ops", g_rd_cyc + g_wr_cyc, 32'd0);
        chk("mis_w_rdata", g_rdata, 32'd0);
        run_req(1'b1, 32'h0000_0001, 2'b01, 1'b0, 32'hFFFF_FFFF, 0, 0);
        chk("mis_h_err", {31'd0, g_err}, 32'd1);
        chk("mis_h_ops", g_rd_cyc + g_wr_cyc, 32'd0);
        run_req(1'b0, 32'h0000_0000, 2'b11, 1'b0, 32'd0, 0, 0);
        chk("sz11_err", {31'd0, g_err}, 32'd1);
        chk("sz11_lat", g_lat, 32'd1);

        // Stall for two cycles mid-access
        bus_if.bus_data_read = 32'h1234_5678;
        run_req(1'b0, 32'h0000_0040, 2'b10, 1'b0, 32'd0, 2, 2);
        chk("stall_rd_cyc", g_rd_cyc, 32'd5);
        chk("stall_lat", g_lat, 32'd6);
        chk("stall_rdata", g_rdata, 32'h1234_5678);
        chk("stall_err", {31'd0, g_err}, 32'd0);

        // Reset during the second access cycle
        @(negedge clk);
        bus_if.req_valid = 1'b1; bus_if.req_write = 1'b0;
        bus_if.req_addr = 32'h0000_0010; bus_if.req_size = 2'b10;
        @(posedge clk);
        #1;
        bus_if.req_valid = 1'b0;
        @(posedge clk);
        #2;
        chk("pre_rst_read_op", {31'd0, bus_if.read_op}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_mid_read_op", {31'd0, bus_if.read_op}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        begin
            int seen;
            seen = 0;
            chk("rst_rel_ready", {31'd0, bus_if.req_ready}, 32'd1);
            repeat (6) begin
                @(negedge clk);
                if (bus_if.resp_valid || bus_if.read_op) seen++;
            end
            chk("rst_no_resp", seen, 32'd0);
        end

        // Normal access after reset
        bus_if.bus_data_read = 32'h1122_3344;
        run_req(1'b0, 32'h0000_0009, 2'b00, 1'b0, 32'd0, 0, 0);
        chk("post_rst_addr", {12'd0, g_addr}, 32'h2);
        chk("post_rst_mask", {28'd0, g_mask}, 32'h2);
        chk("post_rst_rdata", g_rdata, 32'h0000_0033);
        chk("post_rst_lat", g_lat, 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
